rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter.sv | 159 +++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 8-requester round-robin arbiter with a registered output mux.
// A request seen in IDLE is granted on the next edge. The winner's lane data is
// captured and held in BUSY until the downstream side accepts it.
// Optional stall timeout: define ARB_TIMEOUT_EN to abort a BUSY transfer after
// TIMEOUT consecutive cycles with out_ready low.
module rr_mux_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [2:0]         sel,
    output logic [7:0]         grant,
    output logic [7:0]         ack,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [2:0]         sel_reg, sel_next;
    logic [7:0]         grant_reg, grant_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   out_data_reg, out_data_next;
    logic               timeout_err_reg, timeout_err_next;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0]      stall_cnt_reg, stall_cnt_next;
`endif

    // Per-lane views of the flat data bus and the scan order starting at ptr.
    logic [WIDTH-1:0]   lane_data [8];
    logic [2:0]         cand_idx  [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign cand_idx[gi]  = ptr_reg + 3'(gi);
        end
    endgenerate

    logic       win_found;
    logic [2:0] win_idx;

    // Priority scan from ptr upward with 3-bit wrap; first requesting lane wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        for (int k = 0; k < 8; k++) begin
            if (!win_found && req[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= 3'd0;
            sel_reg         <= 3'd0;
            grant_reg       <= 8'd0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            timeout_err_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            stall_cnt_reg   <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            sel_reg         <= sel_next;
            grant_reg       <= grant_next;
            out_valid_reg   <= out_valid_next;
            out_data_reg    <= out_data_next;
            timeout_err_reg <= timeout_err_next;
`ifdef ARB_TIMEOUT_EN
            stall_cnt_reg   <= stall_cnt_next;
`endif
        end
    end

    // Next-state logic: grant from IDLE, hold in BUSY until accepted (or aborted).
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        sel_next         = sel_reg;
        grant_next       = grant_reg;
        out_valid_next   = out_valid_reg;
        out_data_next    = out_data_reg;
        timeout_err_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
        stall_cnt_next   = stall_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                grant_next     = 8'd0;
                out_valid_next = 1'b0;
                if (win_found) begin
                    state_next     = ST_BUSY;
                    sel_next       = win_idx;
                    grant_next     = 8'(1) << win_idx;
                    out_data_next  = lane_data[win_idx];
                    out_valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    stall_cnt_next = '0;
`endif
                end
            end
            ST_BUSY: begin
                // out_ready wins over a coinciding timeout.
                if (out_ready) begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b0;
                    grant_next     = 8'd0;
                    ptr_next       = sel_reg + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    stall_cnt_next = '0;
                end else if (stall_cnt_reg == CW'(TIMEOUT - 1)) begin
                    state_next       = ST_IDLE;
                    out_valid_next   = 1'b0;
                    grant_next       = 8'd0;
                    ptr_next         = sel_reg + 3'd1;
                    timeout_err_next = 1'b1;
                    stall_cnt_next   = '0;
                end else begin
                    stall_cnt_next = stall_cnt_reg + CW'(1);
`endif
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign sel         = sel_reg;
    assign grant       = grant_reg;
    assign busy        = (state_reg == ST_BUSY);
    assign timeout_err = timeout_err_reg;
    // Completion pulse: only the granted lane, only while its data is accepted.
    assign ack         = grant_reg & {8{out_valid_reg & out_ready}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed stimulus pushes the expected
// (lane, data) of each completed transfer; a monitor pops on every accepted beat.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst_n;
    logic [7:0]         req;
    logic [8*WIDTH-1:0] in_data;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic [2:0]         sel;
    logic [7:0]         grant;
    logic [7:0]         ack;
    logic               busy;
    logic               timeout_err;

    rr_mux_arbiter #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .in_data     (in_data),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .sel         (sel),
        .grant       (grant),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [2:0]       lane;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_xfer   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_val);
        checks++;
        if (act !== req_val) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic push(input logic [2:0] lane, input logic [WIDTH-1:0] data);
        exp_t e;
        e.lane = lane;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Holds req for n full grant/transfer pairs (two cycles each), then drops it.
    task automatic run_grants(input logic [7:0] r, input int n);
        req = r;
        repeat (2 * n) tick();
        req = 8'h00;
    endtask

    // Monitor: every accepted beat must match the next expected transfer.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_xfer sel=%0d data=%0h required=none", sel, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_xfer++;
                check("xfer_sel",   64'(sel),      64'(e.lane));
                check("xfer_grant", 64'(grant),    64'(8'(1) << e.lane));
                check("xfer_ack",   64'(ack),      64'(8'(1) << e.lane));
                check("xfer_data",  64'(out_data), 64'(e.data));
                $display("xfer %0d: lane=%0d data=%08h ack=%02h", n_xfer, sel, out_data, ack);
            end
        end else if (ack != 8'h00) begin
            check("ack_idle", 64'(ack), 64'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req       = 8'h00;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid),   64'h0);
        check("rst_grant", 64'(grant),       64'h0);
        check("rst_sel",   64'(sel),         64'h0);
        check("rst_data",  64'(out_data),    64'h0);
        check("rst_terr",  64'(timeout_err), 64'h0);
        check("rst_busy",  64'(busy),        64'h0);
        #2 rst_n = 1'b1;
        tick();
        check("idle_valid", 64'(out_valid), 64'h0);

        // Round robin from ptr 0: lanes 0..7 then 0 again.
        for (int i = 0; i < 8; i++) set_lane(i, WIDTH'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) push(3'(i % 8), WIDTH'(i % 8));
        run_grants(8'hFF, 9);

        // Single request, ptr now 1; one-cycle grant latency.
        set_lane(2, 32'hDEAD_BEEF);
        push(3'd2, 32'hDEAD_BEEF);
        check("lat_pre_valid", 64'(out_valid), 64'h0);
        req = 8'h04;
        tick();
        check("lat_valid", 64'(out_valid), 64'h1);
        check("lat_busy",  64'(busy),      64'h1);
        tick();
        req = 8'h00;

        // Wrap: lane 5 leaves ptr at 6, then 8'h41 gives 6, 0, 6.
        set_lane(6, 32'h0000_0066);
        set_lane(0, 32'h0000_00A0);
        push(3'd5, 32'h5);
        run_grants(8'h20, 1);
        push(3'd6, 32'h66);
        push(3'd0, 32'hA0);
        push(3'd6, 32'h66);
        run_grants(8'h41, 3);

        // Backpressure on lane 3 (ptr 7 -> scan reaches 3).
        set_lane(3, 32'h3333_0003);
        out_ready = 1'b0;
        req = 8'h08;
        tick();
        req = 8'h00;
        set_lane(3, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            check("bp_data",  64'(out_data), 64'h3333_0003);
            check("bp_grant", 64'(grant),    64'h08);
            check("bp_ack",   64'(ack),      64'h00);
            tick();
        end
        push(3'd3, 32'h3333_0003);
        out_ready = 1'b1;
        tick();
        check("bp_after_valid", 64'(out_valid), 64'h0);
        check("bp_after_ack",   64'(ack),       64'h00);

        // Stall on lane 1 (ptr 4 -> scan wraps to 1).
        out_ready = 1'b0;
        req = 8'h02;
        tick();
        req = 8'h00;
        check("stall_sel", 64'(sel), 64'h1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_wait_valid", 64'(out_valid),   64'h1);
            check("to_wait_terr",  64'(timeout_err), 64'h0);
        end
        tick();
        check("to_terr",  64'(timeout_err), 64'h1);
        check("to_valid", 64'(out_valid),   64'h0);
        check("to_grant", 64'(grant),       64'h00);
        tick();
        check("to_terr_pulse", 64'(timeout_err), 64'h0);
        push(3'd2, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        run_grants(8'h06, 1);
        out_ready = 1'b0;
        req = 8'h10;
        tick();
        req = 8'h00;
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            check("stall_valid", 64'(out_valid),   64'h1);
            check("stall_terr",  64'(timeout_err), 64'h0);
        end
`endif

        // Reset while BUSY: immediate clear, then ptr 0 scan reaches lane 7.
        check("pre_rst_valid", 64'(out_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_grant", 64'(grant),     64'h00);
        check("mid_rst_sel",   64'(sel),       64'h0);
        check("mid_rst_ack",   64'(ack),       64'h00);
        check("mid_rst_busy",  64'(busy),      64'h0);
        #3 rst_n = 1'b1;
        tick();
        set_lane(7, 32'h7777_0007);
        push(3'd7, 32'h7777_0007);
        out_ready = 1'b1;
        req = 8'h80;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h1);
        tick();
        req = 8'h00;
        repeat (3) tick();

        check("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
